// File: rtl/dsram_pkg.sv
// Shared types and constants for the data-SRAM responder.
// The response queue entry carries load data, a store flag and a countdown to data_ok.
package dsram_pkg;
   localparam int WORD_W = 32;
   localparam int STRB_W = 4;
   localparam int CNT_W  = 5;

   // Fibonacci taps 16,14,13,11 (bit 15 is tap 16)
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef struct packed {
      logic [WORD_W-1:0] rdata;
      logic              is_wr;
      logic [CNT_W-1:0]  cnt;
   } dsram_entry_t;

   function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] c);
      return (c == '0) ? c : c - CNT_W'(1);
   endfunction
endpackage

// File: rtl/dsram_resp_fifo.sv
// In-order response queue of dsram_entry_t; every stored countdown ticks toward zero each cycle.
// Entry payload is not reset; validity is tracked by the pointers and count alone.
module dsram_resp_fifo
   import dsram_pkg::*;
#(
   parameter int  OSTD = 2,
   localparam int CW   = $clog2(OSTD + 1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  dsram_entry_t push_entry,
   input  logic         pop,
   output dsram_entry_t head,
   output dsram_entry_t head_next,
   output logic [CW-1:0] count,
   output logic         full
);
   localparam int PW = (OSTD > 1) ? $clog2(OSTD) : 1;

   dsram_entry_t   q [OSTD];
   logic [PW-1:0]  rd_ptr;
   logic [PW-1:0]  wr_ptr;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(OSTD - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // A freshly pushed entry keeps its loaded countdown for its first cycle
   always_ff @(posedge clk) begin
      for (int i = 0; i < OSTD; i++) q[i].cnt <= cnt_dec(q[i].cnt);
      if (push) q[wr_ptr] <= push_entry;
   end

   assign head      = q[rd_ptr];
   assign head_next = q[ptr_inc(rd_ptr)];
   assign full      = (count == CW'(OSTD));
endmodule

// File: rtl/data_sram_responder.sv
// Data-SRAM responder: byte-lane word RAM with in-order, fixed-latency load/store responses.
// Define DSRAM_RAND_DELAY_EN to add LFSR-driven request stalls and extra response delay.
module data_sram_responder
   import dsram_pkg::*;
#(
   parameter int          DEPTH_LOG2 = 16,
   parameter int          LATENCY    = 1,
   parameter int          OSTD       = 2,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              wr,
   input  logic [1:0]        size,
   input  logic [STRB_W-1:0] wstrb,
   input  logic [31:0]       addr,
   input  logic [WORD_W-1:0] wdata,
   output logic              addr_ok,
   output logic              data_ok,
   output logic [WORD_W-1:0] rdata
);
   localparam int CW = $clog2(OSTD + 1);

   logic [WORD_W-1:0]     mem [0:(1 << DEPTH_LOG2) - 1];
   logic [DEPTH_LOG2-1:0] widx;
   logic                  accept;
   logic                  pop;
   logic                  full;
   logic [CW-1:0]         count;
   logic                  gate;
   logic [CNT_W-1:0]      extra;
   dsram_entry_t          push_entry;
   dsram_entry_t          head;
   dsram_entry_t          head_next;
   dsram_entry_t          cand;
   logic                  cand_vld;
   logic                  cand_new;
   logic [CNT_W-1:0]      cand_cnt;
   logic                  unused_bits;

   assign unused_bits = ^{size, addr};
   assign widx        = addr[DEPTH_LOG2+1:2];

`ifdef DSRAM_RAND_DELAY_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk) begin
      if (reset) lfsr <= LFSR_SEED;
      else       lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
   end

   assign gate  = (lfsr[1:0] != 2'b00);
   assign extra = CNT_W'(lfsr[3:2]);
`else
   localparam logic [15:0] unused_seed = LFSR_SEED;

   assign gate  = 1'b1;
   assign extra = '0;
`endif

   // data_ok high means the head retires this cycle, freeing a slot
   assign pop     = data_ok;
   assign addr_ok = !reset && gate && (!full || pop);
   assign accept  = req && addr_ok;

   always_comb begin
      push_entry.rdata = mem[widx];
      push_entry.is_wr = wr;
      push_entry.cnt   = CNT_W'(LATENCY - 1) + extra;
   end

   always_ff @(posedge clk) begin
      if (accept && wr) begin
         for (int b = 0; b < STRB_W; b++)
            if (wstrb[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
   end

   dsram_resp_fifo #(.OSTD(OSTD)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (accept),
      .push_entry (push_entry),
      .pop        (pop),
      .head       (head),
      .head_next  (head_next),
      .count      (count),
      .full       (full)
   );

   // Entry that will sit at the head next cycle, and its countdown after this edge
   always_comb begin
      cand     = push_entry;
      cand_vld = accept;
      cand_new = 1'b1;
      if (pop) begin
         if (count > CW'(1)) begin
            cand     = head_next;
            cand_vld = 1'b1;
            cand_new = 1'b0;
         end
      end else if (count != '0) begin
         cand     = head;
         cand_vld = 1'b1;
         cand_new = 1'b0;
      end
      cand_cnt = cand_new ? cand.cnt : cnt_dec(cand.cnt);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_ok <= 1'b0;
         rdata   <= '0;
      end else begin
         data_ok <= cand_vld && (cand_cnt == '0);
         rdata   <= (cand_vld && (cand_cnt == '0) && !cand.is_wr) ? cand.rdata : '0;
      end
   end
endmodule
